obstacle_scroller: RTL
======================

// Module: obstacle_scroller
// PURPOSE
//  Source of every obstacle coordinate the crash checker consumes: two scrolling mountains and one falling lava block.
//  Runs a frame-rate state machine, advances positions once per frame tick and respawns obstacles at pseudo-random spots.
//  Freezes all motion when game_over is asserted. Sits between the game controller (start) and the crash checker and VGA renderer.
// PARAMETERS
//  SCREEN_W     160     visible width in pixels; x coordinates are 10-bit
//  SCREEN_H     120     visible height in pixels
//  FRAME_DIV    833333  clk cycles per frame tick (60 Hz at 50 MHz); minimum 2
//  MTN_SPACING  80      initial x gap between mountain1 and mountain2
//  MTN_MIN_H    16      minimum mountain height above screen bottom
//  LAVA_X_MIN   40      lowest lava spawn x
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  start          in   1   level; begins or restarts a game
//  game_over      in   1   level from crash checker; freezes motion
//  mountain1_x    out  10  left edge of mountain 1
//  mountain1_y    out  10  top of mountain 1
//  mountain2_x    out  10  left edge of mountain 2
//  mountain2_y    out  10  top of mountain 2
//  lava_x         out  10  left edge of the 16x16 lava block
//  lava_y         out  10  top of the 16x16 lava block
//  score          out  8   mountains passed, saturating
//  frame_update   out  1   1-cycle pulse: positions changed this cycle
//  running        out  1   1 while in RUN
// BEHAVIOUR
//  Reset (and entry to IDLE):
//   - m1_x=SCREEN_W-1, m2_x=SCREEN_W-1+MTN_SPACING, m1_y=m2_y=SCREEN_H-MTN_MIN_H
//   - lava_x=LAVA_X_MIN, lava_y=0
//   - score=0, frame_update=0, running=0, frame counter=0, LFSR=10'h2A5
//  Clock: one clock and one reset. The reset is synchronous and active-high.
//  LFSR: 10-bit Fibonacci, taps 10 and 7. It advances every clk in all states except reset, so the value seen at start depends on time.
//  Frame tick: counter runs 0..FRAME_DIV-1 only in RUN and is held at 0 otherwise. tick=1 on the cycle the counter equals FRAME_DIV-1.
//  FSM: IDLE, RUN, OVER (shared encoding).
//   - IDLE -> RUN when start=1
//   - RUN -> OVER when game_over=1
//   - OVER -> IDLE when start=1 and game_over=0; this reloads the reset positions
//   - If game_over and tick occur in the same cycle, game_over wins: no update, and frame_update stays 0.
//  On tick in RUN, with speed = 1 + score[7:5] (range 1..8), for each mountain:
//   - if x >= speed: x <= x - speed
//   - else (wrap): x <= SCREEN_W-1, y <= SCREEN_H-MTN_MIN_H-lfsr[4:0], score <= score+1, saturating at 255
//   - if both mountains wrap on the same tick, score +2 (saturating) and both draw from the same LFSR value
//  Lava on tick:
//   - if lava_y+1 > SCREEN_H-16: respawn with lava_y <= 0, lava_x <= LAVA_X_MIN+lfsr[5:0]
//   - else lava_y <= lava_y+1
//  frame_update is registered and high in exactly the cycle the new positions appear at the outputs.
//  All outputs are registered. Latency: tick -> new positions is 1 clk.
//  OVER: every position and score holds its last value. running=0.
//  Reset mid-game: the next cycle shows the reset values, whatever the state.
//  Arithmetic is 10-bit unsigned. Wrap detection uses compare-before-subtract, so underflow never occurs.
// STRUCTURE
//  game_pkg: SCREEN_W/SCREEN_H defaults, the 16-px lava and plane size, and the FSM state typedef/localparams.
//   The crash checker uses the same package.
//  Sub-module lfsr10 (clk, reset, seed, q[9:0]) is shared with the plane/terrain generators.
//  Everything else lives in obstacle_scroller: FSM, frame divider, position datapath, score.
// TESTING (FRAME_DIV=4 for all benches)
//  1) reset then idle 20 clk -> m1_x=159, m2_x=239, lava_y=0, score=0, frame_update never 1
//  2) start=1 -> first frame_update 4 clk later (counter holds 0 in the start cycle) with m1_x=158, m2_x=238, lava_y=1; pulse is exactly 1 clk wide
//  3) run 160 ticks -> m1 wraps to 159 with y in 73..104, score=1, m2_x=79 unaffected
//  4) force score=32 (speed 2) with m1_x=1 -> next tick m1_x=159 (wrap, no underflow); m1_x=2 -> 0
//  5) game_over=1 on the tick cycle -> no frame_update, positions frozen for 50 clk; start with game_over=0 -> IDLE reset values
//  6) lava_y=104 on tick -> lava_y=0, lava_x in 40..103; reset asserted mid-RUN -> all outputs at reset values the next clk

Source files
------------

// File: rtl/game_pkg.sv
// Package: game_pkg
// Shared geometry and FSM encoding for the obstacle scroller and the crash
// checker. Both blocks must agree on screen size, obstacle size and the
// game-state encoding, so they live here rather than in either module.
package game_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int OBJ_SIZE     = 16;   // lava block and plane are 16x16

    localparam logic [9:0] LFSR_SEED = 10'h2A5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/obstacle_scroller_lfsr10.sv
// Module: lfsr10
// 10-bit Fibonacci LFSR, taps 10 and 7 (x^10 + x^7 + 1, maximal length).
// Loads seed while reset is high, otherwise advances every clock.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; loads seed
//   seed   in   10-bit reload value (must be non-zero)
//   q      out  current LFSR state
module lfsr10 (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] seed,
    output logic [9:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= seed;
        else       q <= {q[8:0], q[9] ^ q[6]};
    end

endmodule

// File: rtl/obstacle_scroller.sv
// Module: obstacle_scroller
// Produces the coordinates of two scrolling mountains and one falling lava
// block. A frame divider generates a tick every FRAME_DIV clocks while the
// game runs; on each tick the obstacles move and respawn at LFSR-chosen spots.
// game_over freezes everything; start from OVER returns to the initial layout.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 level; begins / restarts a game
//   game_over             level; freezes motion
//   mountain{1,2}_{x,y}   mountain left edge / top
//   lava_x, lava_y        lava block left edge / top
//   score                 mountains passed, saturating at 255
//   frame_update          1-cycle pulse in the cycle new positions appear
//   running               high while in RUN
module obstacle_scroller
    import game_pkg::*;
#(
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int FRAME_DIV   = 833333,
    parameter int MTN_SPACING = 80,
    parameter int MTN_MIN_H   = 16,
    parameter int LAVA_X_MIN  = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       game_over,
    output logic [9:0] mountain1_x,
    output logic [9:0] mountain1_y,
    output logic [9:0] mountain2_x,
    output logic [9:0] mountain2_y,
    output logic [9:0] lava_x,
    output logic [9:0] lava_y,
    output logic [7:0] score,
    output logic       frame_update,
    output logic       running
);

    localparam int              CNT_W      = $clog2(FRAME_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_DIV - 1);
    localparam logic [9:0]      M1_X0      = 10'(SCREEN_W - 1);
    localparam logic [9:0]      M2_X0      = 10'(SCREEN_W - 1 + MTN_SPACING);
    localparam logic [9:0]      MTN_Y0     = 10'(SCREEN_H - MTN_MIN_H);
    localparam logic [9:0]      LAVA_X0    = 10'(LAVA_X_MIN);
    localparam logic [9:0]      LAVA_Y_MAX = 10'(SCREEN_H - OBJ_SIZE);

    game_state_t      state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       lfsr;
    logic             tick, update, reload;

    logic [9:0] speed, spawn_y;
    logic       m1_wrap, m2_wrap, lava_respawn;
    logic [9:0] m1_x_n, m2_x_n, lava_x_n, lava_y_n;
    logic [8:0] score_sum;
    logic [7:0] score_n;
    logic       unused_lfsr_hi;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[9:6];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        reload  = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_RUN;
            ST_RUN:  if (game_over) state_n = ST_OVER;
            ST_OVER: if (start && !game_over) begin
                state_n = ST_IDLE;
                reload  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------- frame divider ----------------
    // Held at 0 outside RUN, so the first tick lands FRAME_DIV cycles after
    // entering RUN.
    assign tick = (state == ST_RUN) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || state != ST_RUN || tick) cnt <= '0;
        else                                  cnt <= cnt + 1'b1;
    end

    // A tick coinciding with game_over is dropped.
    assign update = tick && !game_over;

    // ---------------- next positions ----------------
    always_comb begin
        speed   = 10'd1 + {7'd0, score[7:5]};
        spawn_y = MTN_Y0 - {5'd0, lfsr[4:0]};

        // Compare before subtracting so x never underflows.
        m1_wrap = mountain1_x < speed;
        m2_wrap = mountain2_x < speed;
        m1_x_n  = m1_wrap ? M1_X0 : mountain1_x - speed;
        m2_x_n  = m2_wrap ? M1_X0 : mountain2_x - speed;

        score_sum = {1'b0, score} + {7'd0, m1_wrap} + {7'd0, m2_wrap};
        score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];

        lava_respawn = (lava_y + 10'd1) > LAVA_Y_MAX;
        lava_y_n     = lava_respawn ? 10'd0 : lava_y + 10'd1;
        lava_x_n     = lava_respawn ? LAVA_X0 + {4'd0, lfsr[5:0]} : lava_x;
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            mountain1_x  <= M1_X0;
            mountain2_x  <= M2_X0;
            mountain1_y  <= MTN_Y0;
            mountain2_y  <= MTN_Y0;
            lava_x       <= LAVA_X0;
            lava_y       <= '0;
            score        <= '0;
            frame_update <= 1'b0;
        end else begin
            frame_update <= update;
            if (update) begin
                mountain1_x <= m1_x_n;
                mountain2_x <= m2_x_n;
                if (m1_wrap) mountain1_y <= spawn_y;
                if (m2_wrap) mountain2_y <= spawn_y;
                lava_x      <= lava_x_n;
                lava_y      <= lava_y_n;
                score       <= score_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) running <= 1'b0;
        else       running <= (state_n == ST_RUN);
    end

endmodule
